calc_seq_engine: RTL and testbench
==================================

Name: calc_seq_engine

Overview:
Parametrised sign-magnitude arithmetic engine that replaces the single-cycle calculate path of the basic calculator.
- Performs add/sub in one execute cycle; multiply and divide iteratively over WIDTH cycles.
- Uses a start/busy/done handshake, supports result chaining, and reports overflow and divide-by-zero errors.
- Sits between the state controller (operands, op, start) and the digit separator/display mux (result, sign, error).

Parameters:
WIDTH, 20, magnitude bits of operands and result.
MAX_MAG, 999999, largest displayable magnitude; constraint MAX_MAG < 2**WIDTH.

Ports:
i_clk  input  1  system clock, rising edge.
i_reset  input  1  synchronous, active-high reset.
i_start  input  1  one-cycle request; sampled only in IDLE.
i_op  input  2  00 add, 01 sub, 10 mul, 11 div.
i_chain  input  1  at start, use the current o_result_mag/o_result_sign as operand A.
i_a_mag  input  WIDTH  operand A magnitude.
i_a_sign  input  1  operand A sign, 1 = negative.
i_b_mag  input  WIDTH  operand B magnitude.
i_b_sign  input  1  operand B sign.
o_busy  output  1  high from the cycle after an accepted start until the cycle o_done is high, inclusive.
o_done  output  1  one-cycle pulse; results are valid from this cycle onward.
o_result_mag  output  WIDTH  result magnitude, held until the next done.
o_result_sign  output  1  result sign; never 1 when magnitude is 0.
o_err  output  1  high while the last completed op errored.
o_err_code  output  2  00 none, 01 overflow/out-of-range, 10 divide by zero.

Behaviour:
- Clock and reset: one clock (i_clk); reset is synchronous and active-high (i_reset). Reset wins over start in the same cycle.
- Reset values: FSM in IDLE; all outputs 0. This applies mid-operation: no done is generated and the operation is abandoned.
- FSM states: IDLE, ADDSUB, MUL_ITER, DIV_ITER, FINISH.
- Operand capture: op, chain, and operands (A from the result regs if i_chain=1) are latched at the accepted start edge (cycle 0). Later input changes are ignored.
- Transitions from IDLE on start:
  - Either latched magnitude > MAX_MAG goes to FINISH with err 01.
  - Else div with B=0 goes to FINISH with err 10.
  - Else add/sub goes to ADDSUB; mul goes to MUL_ITER; div goes to DIV_ITER.
- Latency (o_done high in cycle N, counting the start cycle as 0): err-at-entry N=1; add/sub N=2; mul/div N=WIDTH+2.
- ADDSUB: sub = add with B sign inverted.
  - Equal signs: add magnitudes (WIDTH+1 bit sum).
  - Unequal signs: larger minus smaller; sign of the larger; equal magnitudes give +0.
- MUL_ITER: shift-add over exactly WIDTH cycles into a 2*WIDTH-bit product; sign = xor.
- DIV_ITER: restoring division over exactly WIDTH cycles; quotient truncated toward zero; sign = xor, forced 0 if quotient is 0; remainder discarded.
- FINISH: overflow if the full-width magnitude > MAX_MAG.
  - On any error: result_mag=0, sign=0, o_err=1, err_code set.
  - Else: result registered, o_err=0, code 00.
  - Then return to IDLE. o_done=1 in FINISH only.
- Start while busy (any state except IDLE) is ignored, not queued.
- Chain after an error uses A = +0.
- Back-to-back: a start in the cycle after FINISH is accepted.

Decomposition:
- Package calc_pkg holds:
  - op encodings (OP_ADD..OP_DIV);
  - error codes (ERR_NONE, ERR_OVF, ERR_DIV0);
  - the state enum.
- One sub-module, seq_muldiv_unit, contains the iterative mul/div datapath and iteration counter.
  - Parameter: WIDTH.
  - Ports: i_clk, i_reset, i_go, i_is_div, i_a, i_b, o_res[2*WIDTH-1:0], o_last.
- Top level holds the FSM, sign logic, add/sub, range checks and result registers.

Test Plan (WIDTH=20, MAX_MAG=999999):
1. Reset, then add A=+1234, B=-5678 -> o_done in cycle 2, result -4444, o_err=0, o_busy high in cycles 1-2.
2. Mul A=+999, B=+1001 -> o_done in cycle 22, +999999. Then chain mul B=+2 -> overflow: err_code 01, result +0.
3. Div A=-100, B=+7 -> -14 in cycle 22. Div A=+5, B=0 -> o_done in cycle 1, err_code 10, result 0.
4. Sub A=+50, B=+50 -> magnitude 0, sign 0. Then chain sub B=+30 -> -30. Then add A=+1000000, B=+1 -> err 01 in cycle 1.
5. Mul with i_start re-pulsed in cycles 3 and 10 -> single done in cycle 22. Separate run: i_reset in cycle 10 of a mul -> o_busy=0 and outputs 0 next cycle, no o_done.
6. Add A=+25, B=0 -> +25. Then chain div B=-5 -> -5. Then a start in the cycle after FINISH is accepted, with o_done as per latency.

Source files
------------

// File: rtl/calc_seq_engine_pkg.sv
// Shared encodings for the sequential calculator engine: opcodes, error codes
// and the controller state type.
package calc_pkg;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    localparam logic [1:0] ERR_NONE = 2'b00;
    localparam logic [1:0] ERR_OVF  = 2'b01;
    localparam logic [1:0] ERR_DIV0 = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_ADDSUB   = 3'd1,
        ST_MUL_ITER = 3'd2,
        ST_DIV_ITER = 3'd3,
        ST_FINISH   = 3'd4
    } state_t;

endpackage

// File: rtl/calc_seq_engine_if.sv
// Request/result bundle between the state controller (master) and the
// arithmetic engine (slave).
interface calc_seq_engine_if #(
    parameter int unsigned WIDTH = 20
);
    logic             i_start;
    logic [1:0]       i_op;
    logic             i_chain;
    logic [WIDTH-1:0] i_a_mag;
    logic             i_a_sign;
    logic [WIDTH-1:0] i_b_mag;
    logic             i_b_sign;
    logic             o_busy;
    logic             o_done;
    logic [WIDTH-1:0] o_result_mag;
    logic             o_result_sign;
    logic             o_err;
    logic [1:0]       o_err_code;

    modport master (
        output i_start, i_op, i_chain, i_a_mag, i_a_sign, i_b_mag, i_b_sign,
        input  o_busy, o_done, o_result_mag, o_result_sign, o_err, o_err_code
    );

    modport slave (
        input  i_start, i_op, i_chain, i_a_mag, i_a_sign, i_b_mag, i_b_sign,
        output o_busy, o_done, o_result_mag, o_result_sign, o_err, o_err_code
    );
endinterface

// File: rtl/calc_seq_engine_muldiv.sv
// Iterative unsigned multiply (shift-add) and divide (restoring) over exactly
// WIDTH steps; o_last is high for the one cycle after the final step.
module seq_muldiv_unit #(
    parameter int unsigned WIDTH = 20
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_go,
    input  logic               i_is_div,
    input  logic [WIDTH-1:0]   i_a,
    input  logic [WIDTH-1:0]   i_b,
    output logic [2*WIDTH-1:0] o_res,
    output logic               o_last
);
    localparam int unsigned    CW       = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0]  CNT_ONE  = CW'(32'd1);

    logic [CW-1:0]      cnt_r;
    logic               is_div_r;
    logic               last_r;
    logic [2*WIDTH-1:0] prod_r;
    logic [2*WIDTH-1:0] mcand_r;
    logic [WIDTH-1:0]   mplier_r;
    logic [WIDTH-1:0]   quo_r;
    logic [WIDTH-1:0]   divisor_r;
    logic [WIDTH-1:0]   rem_r;
    logic [WIDTH:0]     shifted_s;
    logic [WIDTH-1:0]   rem_nx_s;
    logic               quo_bit_s;

    // Restoring-division trial subtract; the remainder always stays below the divisor
    always_comb begin
        shifted_s = {rem_r, quo_r[WIDTH-1]};
        if (shifted_s >= {1'b0, divisor_r}) begin
            rem_nx_s  = WIDTH'(shifted_s - {1'b0, divisor_r});
            quo_bit_s = 1'b1;
        end else begin
            rem_nx_s  = shifted_s[WIDTH-1:0];
            quo_bit_s = 1'b0;
        end
    end

    // Operand load on go, then one multiply and one divide step per cycle
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            cnt_r     <= '0;
            is_div_r  <= 1'b0;
            last_r    <= 1'b0;
            prod_r    <= '0;
            mcand_r   <= '0;
            mplier_r  <= '0;
            quo_r     <= '0;
            divisor_r <= '0;
            rem_r     <= '0;
        end else if (i_go) begin
            cnt_r     <= CNT_FULL;
            is_div_r  <= i_is_div;
            last_r    <= 1'b0;
            prod_r    <= '0;
            mcand_r   <= {{WIDTH{1'b0}}, i_a};
            mplier_r  <= i_b;
            quo_r     <= i_a;
            divisor_r <= i_b;
            rem_r     <= '0;
        end else if (cnt_r != '0) begin
            cnt_r    <= cnt_r - CNT_ONE;
            last_r   <= (cnt_r == CNT_ONE);
            if (mplier_r[0]) begin
                prod_r <= prod_r + mcand_r;
            end
            mcand_r  <= {mcand_r[2*WIDTH-2:0], 1'b0};
            mplier_r <= {1'b0, mplier_r[WIDTH-1:1]};
            rem_r    <= rem_nx_s;
            quo_r    <= {quo_r[WIDTH-2:0], quo_bit_s};
        end else begin
            last_r <= 1'b0;
        end
    end

    assign o_res  = is_div_r ? {{WIDTH{1'b0}}, quo_r} : prod_r;
    assign o_last = last_r;

endmodule

// File: rtl/calc_seq_engine.sv
// Sign-magnitude calculator engine: start/busy/done control, add/sub in one
// execute cycle, iterative mul/div, range and divide-by-zero reporting.
module calc_seq_engine
    import calc_pkg::*;
#(
    parameter int unsigned WIDTH   = 20,
    parameter int unsigned MAX_MAG = 32'd999999
) (
    input  logic             i_clk,
    input  logic             i_reset,
    calc_seq_engine_if.slave bus
);
    localparam logic [WIDTH-1:0]   MAX_W  = WIDTH'(MAX_MAG);
    localparam logic [2*WIDTH-1:0] MAX_2W = (2*WIDTH)'(MAX_MAG);

    state_t             state_r;
    state_t             state_nx_s;
    logic               busy_r;
    logic               done_r;
    logic [WIDTH-1:0]   res_mag_r;
    logic               res_sign_r;
    logic               err_r;
    logic [1:0]         err_code_r;
    logic [WIDTH-1:0]   a_mag_r;
    logic [WIDTH-1:0]   b_mag_r;
    logic               a_sign_r;
    logic               b_sign_r;

    logic [WIDTH-1:0]   cap_a_mag_s;
    logic               cap_a_sign_s;
    logic               cap_b_sign_s;
    logic               range_err_s;
    logic               div0_s;
    logic [WIDTH:0]     as_mag_s;
    logic               as_sign_s;
    logic [2*WIDTH-1:0] fin_mag_s;
    logic               raw_sign_s;
    logic               fin_sign_s;
    logic               ovf_s;
    logic               capture_s;
    logic               go_s;
    logic               load_s;
    logic [WIDTH-1:0]   ld_mag_s;
    logic               ld_sign_s;
    logic [1:0]         ld_code_s;
    logic [2*WIDTH-1:0] md_res_s;
    logic               md_last_s;

    seq_muldiv_unit #(.WIDTH(WIDTH)) u_muldiv (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_go     (go_s),
        .i_is_div (bus.i_op == OP_DIV),
        .i_a      (cap_a_mag_s),
        .i_b      (bus.i_b_mag),
        .o_res    (md_res_s),
        .o_last   (md_last_s)
    );

    // Operand A comes from the held result when chaining; sub folds into add via B's sign
    always_comb begin
        cap_a_mag_s  = bus.i_chain ? res_mag_r  : bus.i_a_mag;
        cap_a_sign_s = bus.i_chain ? res_sign_r : bus.i_a_sign;
        cap_b_sign_s = (bus.i_op == OP_SUB) ? ~bus.i_b_sign : bus.i_b_sign;
        range_err_s  = (cap_a_mag_s > MAX_W) || (bus.i_b_mag > MAX_W);
        div0_s       = (bus.i_op == OP_DIV) && (bus.i_b_mag == '0);
    end

    // Signed add of two magnitudes: larger minus smaller when signs differ
    always_comb begin
        if (a_sign_r == b_sign_r) begin
            as_mag_s  = {1'b0, a_mag_r} + {1'b0, b_mag_r};
            as_sign_s = a_sign_r;
        end else if (a_mag_r >= b_mag_r) begin
            as_mag_s  = {1'b0, a_mag_r - b_mag_r};
            as_sign_s = a_sign_r;
        end else begin
            as_mag_s  = {1'b0, b_mag_r - a_mag_r};
            as_sign_s = b_sign_r;
        end
    end

    // Full-width result ahead of the range check; a zero magnitude is always positive
    always_comb begin
        if (state_r == ST_ADDSUB) begin
            fin_mag_s  = {{(WIDTH-1){1'b0}}, as_mag_s};
            raw_sign_s = as_sign_s;
        end else begin
            fin_mag_s  = md_res_s;
            raw_sign_s = a_sign_r ^ b_sign_r;
        end
        ovf_s      = (fin_mag_s > MAX_2W);
        fin_sign_s = raw_sign_s & (fin_mag_s != '0);
    end

    // Next state plus the capture/launch/result-load strobes
    always_comb begin
        state_nx_s = state_r;
        capture_s  = 1'b0;
        go_s       = 1'b0;
        load_s     = 1'b0;
        ld_mag_s   = '0;
        ld_sign_s  = 1'b0;
        ld_code_s  = ERR_NONE;
        case (state_r)
            ST_IDLE: begin
                if (bus.i_start) begin
                    capture_s = 1'b1;
                    if (range_err_s) begin
                        state_nx_s = ST_FINISH;
                        load_s     = 1'b1;
                        ld_code_s  = ERR_OVF;
                    end else if (div0_s) begin
                        state_nx_s = ST_FINISH;
                        load_s     = 1'b1;
                        ld_code_s  = ERR_DIV0;
                    end else begin
                        case (bus.i_op)
                            OP_MUL: begin
                                state_nx_s = ST_MUL_ITER;
                                go_s       = 1'b1;
                            end
                            OP_DIV: begin
                                state_nx_s = ST_DIV_ITER;
                                go_s       = 1'b1;
                            end
                            default: state_nx_s = ST_ADDSUB;
                        endcase
                    end
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_ADDSUB, ST_MUL_ITER, ST_DIV_ITER: begin
                if ((state_r == ST_ADDSUB) || md_last_s) begin
                    state_nx_s = ST_FINISH;
                    load_s     = 1'b1;
                    if (ovf_s) begin
                        ld_code_s = ERR_OVF;
                    end else begin
                        ld_mag_s  = fin_mag_s[WIDTH-1:0];
                        ld_sign_s = fin_sign_s;
                    end
                end else begin
                    state_nx_s = state_r;
                end
            end
            ST_FINISH: state_nx_s = ST_IDLE;
            default:   state_nx_s = ST_IDLE;
        endcase
    end

    // State, operand capture and registered result/handshake outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_r    <= ST_IDLE;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            res_mag_r  <= '0;
            res_sign_r <= 1'b0;
            err_r      <= 1'b0;
            err_code_r <= ERR_NONE;
            a_mag_r    <= '0;
            b_mag_r    <= '0;
            a_sign_r   <= 1'b0;
            b_sign_r   <= 1'b0;
        end else begin
            state_r <= state_nx_s;
            busy_r  <= (state_nx_s != ST_IDLE);
            done_r  <= load_s;
            if (capture_s) begin
                a_mag_r  <= cap_a_mag_s;
                a_sign_r <= cap_a_sign_s;
                b_mag_r  <= bus.i_b_mag;
                b_sign_r <= cap_b_sign_s;
            end
            if (load_s) begin
                res_mag_r  <= ld_mag_s;
                res_sign_r <= ld_sign_s;
                err_r      <= (ld_code_s != ERR_NONE);
                err_code_r <= ld_code_s;
            end
        end
    end

    assign bus.o_busy        = busy_r;
    assign bus.o_done        = done_r;
    assign bus.o_result_mag  = res_mag_r;
    assign bus.o_result_sign = res_sign_r;
    assign bus.o_err         = err_r;
    assign bus.o_err_code    = err_code_r;

endmodule

// File: tb/tb_calc_seq_engine.sv
// Scoreboard bench for calc_seq_engine: an integer-arithmetic reference model
// predicts each result and its done cycle; a negedge monitor checks them.
module tb_calc_seq_engine;
    import calc_pkg::*;

    localparam int     W    = 20;
    localparam longint MAXM = 64'd999999;

    typedef struct {
        int     done_cyc;
        longint mag;
        bit     sign;
        bit     err;
        int     code;
    } exp_t;

    logic   clk = 1'b0;
    logic   rst = 1'b1;
    int     cyc = 0;
    int     checks = 0;
    int     errors = 0;
    int     win_lo = 1;
    int     win_hi = 0;
    longint model_last = 0;
    exp_t   sb[$];

    calc_seq_engine_if #(.WIDTH(W)) bus ();

    calc_seq_engine #(.WIDTH(W), .MAX_MAG(32'd999999)) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: actual %0d required %0d at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic longint mag_of(input longint v);
        return (v < 0) ? -v : v;
    endfunction

    // Monitor: done pulse and busy window every cycle; results when done is due
    always @(negedge clk) begin
        bit   exp_done;
        exp_t e;
        exp_done = (sb.size() > 0) && (sb[0].done_cyc == cyc);
        check("o_done", bus.o_done, exp_done);
        check("o_busy", bus.o_busy, (cyc >= win_lo) && (cyc <= win_hi));
        if (exp_done) begin
            e = sb.pop_front();
            check("result_mag", bus.o_result_mag, e.mag);
            check("result_sign", bus.o_result_sign, e.sign);
            check("err", bus.o_err, e.err);
            check("err_code", bus.o_err_code, e.code);
        end
    end

    // Issue one operation at posedge+1; optional re-pulses of start or a mid-op reset
    task automatic issue(input logic [1:0] op, input bit chain, input int a_mag, input bit a_sign,
                         input int b_mag, input bit b_sign,
                         input int pulse_a, input int pulse_b, input int reset_at);
        longint av, bv, r;
        exp_t   e;
        int     s, lat;
        av = chain ? model_last : (a_sign ? -longint'(a_mag) : longint'(a_mag));
        bv = b_sign ? -longint'(b_mag) : longint'(b_mag);
        e.err = 1'b1; e.mag = 0; e.sign = 1'b0; r = 0;
        if (mag_of(av) > MAXM || longint'(b_mag) > MAXM) begin
            e.code = ERR_OVF; lat = 1;
        end else if (op == OP_DIV && bv == 0) begin
            e.code = ERR_DIV0; lat = 1;
        end else begin
            case (op)
                OP_ADD:  r = av + bv;
                OP_SUB:  r = av - bv;
                OP_MUL:  r = av * bv;
                default: r = av / bv;
            endcase
            lat = (op == OP_MUL || op == OP_DIV) ? W + 2 : 2;
            if (mag_of(r) > MAXM) begin
                e.code = ERR_OVF;
            end else begin
                e.err = 1'b0; e.code = ERR_NONE; e.mag = mag_of(r); e.sign = (r < 0);
            end
        end
        model_last = e.err ? 0 : r;

        s = cyc;
        bus.i_op = op; bus.i_chain = chain;
        bus.i_a_mag = W'(a_mag); bus.i_a_sign = a_sign;
        bus.i_b_mag = W'(b_mag); bus.i_b_sign = b_sign;
        bus.i_start = 1'b1;
        e.done_cyc = s + lat;
        sb.push_back(e);
        win_lo = s + 1;
        win_hi = s + lat;

        for (int k = 1; k <= 60; k++) begin
            @(posedge clk); #1;
            bus.i_start = (k == pulse_a) || (k == pulse_b);
            bus.i_op = 2'($urandom); bus.i_chain = 1'($urandom);
            bus.i_a_mag = W'($urandom); bus.i_a_sign = 1'($urandom);
            bus.i_b_mag = W'($urandom); bus.i_b_sign = 1'($urandom);
            if (k == reset_at) begin
                rst = 1'b1; sb.delete(); win_hi = cyc; model_last = 0;
            end else if (reset_at > 0 && k == reset_at + 1) begin
                rst = 1'b0;
                check("rst_busy", bus.o_busy, 1'b0);
                check("rst_done", bus.o_done, 1'b0);
                check("rst_mag", bus.o_result_mag, 0);
                check("rst_sign", bus.o_result_sign, 1'b0);
                check("rst_err", bus.o_err, 1'b0);
                check("rst_code", bus.o_err_code, 0);
            end
            if (reset_at > 0) begin
                if (k >= reset_at + 25) break;
            end else if (sb.size() == 0) begin
                break;
            end
            if (k == 60) begin
                check("completion_timeout", sb.size(), 0);
                sb.delete(); win_hi = cyc;
            end
        end
        bus.i_start = 1'b0;
    endtask

    function automatic int pick_mag();
        case ($urandom_range(0, 9))
            0:       return 0;
            1:       return 999999;
            2:       return int'($urandom_range(1000000, 1048575));
            3, 4, 5: return int'($urandom_range(0, 1000));
            default: return int'($urandom_range(0, 999999));
        endcase
    endfunction

    initial begin
        bus.i_start = 1'b0; bus.i_op = 2'b00; bus.i_chain = 1'b0;
        bus.i_a_mag = '0; bus.i_a_sign = 1'b0; bus.i_b_mag = '0; bus.i_b_sign = 1'b0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset_busy", bus.o_busy, 1'b0);
        check("reset_done", bus.o_done, 1'b0);
        check("reset_mag", bus.o_result_mag, 0);
        check("reset_sign", bus.o_result_sign, 1'b0);
        check("reset_err", bus.o_err, 1'b0);
        check("reset_code", bus.o_err_code, 0);

        issue(OP_ADD, 1'b0, 1234, 1'b0, 5678, 1'b1, 0, 0, 0);
        issue(OP_MUL, 1'b0, 999, 1'b0, 1001, 1'b0, 0, 0, 0);
        issue(OP_MUL, 1'b1, 7, 1'b1, 2, 1'b0, 0, 0, 0);
        issue(OP_DIV, 1'b0, 100, 1'b1, 7, 1'b0, 0, 0, 0);
        issue(OP_DIV, 1'b0, 5, 1'b0, 0, 1'b0, 0, 0, 0);
        issue(OP_SUB, 1'b0, 50, 1'b0, 50, 1'b0, 0, 0, 0);
        issue(OP_SUB, 1'b1, 0, 1'b0, 30, 1'b0, 0, 0, 0);
        issue(OP_ADD, 1'b0, 1000000, 1'b0, 1, 1'b0, 0, 0, 0);
        issue(OP_MUL, 1'b0, 123, 1'b0, 456, 1'b1, 3, 10, 0);
        issue(OP_MUL, 1'b0, 321, 1'b1, 654, 1'b0, 0, 0, 10);
        issue(OP_ADD, 1'b0, 25, 1'b0, 0, 1'b0, 0, 0, 0);
        issue(OP_DIV, 1'b1, 0, 1'b0, 5, 1'b1, 0, 0, 0);
        issue(OP_ADD, 1'b1, 3, 1'b0, 0, 1'b1, 0, 0, 0);

        for (int n = 0; n < 40; n++) begin
            int am, bm;
            am = pick_mag();
            bm = pick_mag();
            issue(2'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), am, 1'($urandom),
                  bm, 1'($urandom), 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
